// File: rtl/fft_pair_feeder.sv
// fft_pair_feeder
//   Collects one frame of P = 2^LOG2_PTS complex samples in bit-reversed
//   order. It then drains the frame as P/2 adjacent butterfly pairs
//   (buf[2r], buf[2r+1]) on consecutive cycles, each with a unity twiddle.
//
// Handshake (input side): a sample transfers on a rising edge where
// in_valid && in_ready. in_ready is high exactly while in FILL and depends
// only on state, never on in_valid. The output side has no backpressure:
// out_valid marks each registered pair for exactly one cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake
//   in_data           {re[N-1:0], im[N-1:0]} sample
//   ifft_in           direction, captured with sample 0 of a frame
//   out_valid         data0/data1/w1/ifft hold a valid pair
//   data0, data1      even / odd operand of the pair
//   w1                twiddle {re, im} in Q1.14 (always 1.0 + j0)
//   ifft              direction latched for the frame being drained
//   frame_done        pulse with the last pair of a frame
//   dbg_state         FSM state (0 = FILL, 1 = DRAIN)
//   dbg_wcnt          write counter
//   dbg_rcnt          pair counter
module fft_pair_feeder #(
  parameter int N        = 28,
  parameter int LOG2_PTS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*N-1:0]      in_data,
  input  logic                ifft_in,
  output logic                out_valid,
  output logic [2*N-1:0]      data0,
  output logic [2*N-1:0]      data1,
  output logic [31:0]         w1,
  output logic                ifft,
  output logic                frame_done,
  output logic                dbg_state,
  output logic [LOG2_PTS-1:0] dbg_wcnt,
  output logic [LOG2_PTS-1:0] dbg_rcnt
);

  localparam int P = 1 << LOG2_PTS;
  localparam logic [LOG2_PTS-1:0] WLAST = LOG2_PTS'(P - 1);
  localparam logic [LOG2_PTS-1:0] RLAST = LOG2_PTS'(P / 2 - 1);
  localparam logic [LOG2_PTS-1:0] ONE   = LOG2_PTS'(1);
  localparam logic [31:0]         TW_ONE = 32'h4000_0000;

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [LOG2_PTS-1:0] wcnt, rcnt;
  logic [LOG2_PTS-1:0] rd0, rd1;
  logic                xfer;
  logic [2*N-1:0]      mem [P];

  function automatic logic [LOG2_PTS-1:0] bitrev(input logic [LOG2_PTS-1:0] a);
    logic [LOG2_PTS-1:0] r;
    for (int i = 0; i < LOG2_PTS; i++) r[i] = a[LOG2_PTS-1-i];
    return r;
  endfunction

  // FILL is the only state that accepts, so in_ready alone gates writes.
  assign xfer = in_valid && (state == FILL);

  // Pair r reads adjacent locations 2r and 2r+1.
  assign rd0 = LOG2_PTS'({rcnt, 1'b0});
  assign rd1 = rd0 | ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && wcnt == WLAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (rcnt == RLAST) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt       <= '0;
      rcnt       <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      data0      <= '0;
      data1      <= '0;
      w1         <= '0;
      ifft       <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (xfer) begin
        wcnt <= wcnt + ONE;
        // Direction is only sampled at sample 0. The previous frame has
        // fully drained by then, so ifft is stable across each frame.
        if (wcnt == '0)   ifft <= ifft_in;
        if (wcnt == WLAST) rcnt <= '0;
      end
      if (state == DRAIN) begin
        data0      <= mem[rd0];
        data1      <= mem[rd1];
        w1         <= TW_ONE;
        out_valid  <= 1'b1;
        frame_done <= (rcnt == RLAST);
        rcnt       <= rcnt + ONE;
      end
    end
  end

  // Sample buffer; contents need no reset because every drained location
  // has been rewritten during the preceding FILL.
  always_ff @(posedge clk) begin
    if (xfer) mem[bitrev(wcnt)] <= in_data;
  end

  assign dbg_state = state;
  assign dbg_wcnt  = wcnt;
  assign dbg_rcnt  = rcnt;

endmodule
